// File: rtl/corr_pkg.sv
// Shared constants and dump-slice helpers for the correlator accumulator bank.
// Widths are default values; modules override them through parameters.
package corr_pkg;

  localparam int CORR_NTAPS   = 5;
  localparam int CORR_IN_W    = 5;
  localparam int CORR_ACC_W   = 19;
  localparam int CORR_OUT_W   = 16;
  localparam int CORR_SHIFT_W = 2;

  // Tap order: very-early, early, prompt, late, very-late.
  localparam int TAP_EE = 0;
  localparam int TAP_E  = 1;
  localparam int TAP_P  = 2;
  localparam int TAP_L  = 3;
  localparam int TAP_LL = 4;

  // Accumulators are sign-extended to this width before slicing so one helper
  // serves every ACC_W up to 64 bits.
  localparam int CORR_EXT_W = 64;
  typedef logic signed [CORR_EXT_W-1:0] corr_ext_t;

  // Plain arithmetic right shift; the caller keeps the low OUT_W bits.
  function automatic corr_ext_t shift_slice(input corr_ext_t acc, input int unsigned s);
    return acc >>> s;
  endfunction

  // Right shift, then clamp to the signed out_w-bit range. Clamping happens
  // exactly when the bits above the kept window disagree with its sign bit.
  function automatic corr_ext_t sat_slice(input corr_ext_t acc, input int unsigned s,
                                          input int unsigned out_w);
    corr_ext_t shifted;
    corr_ext_t hi;
    corr_ext_t lo;
    shifted = acc >>> s;
    hi      = (corr_ext_t'(1) <<< (out_w - 1)) - corr_ext_t'(1);
    lo      = -hi - corr_ext_t'(1);
    if (shifted > hi) return hi;
    if (shifted < lo) return lo;
    return shifted;
  endfunction

endpackage

// File: rtl/corr_accum_lane.sv
// One I or Q lane: integrate-and-dump accumulator plus the dump latch.
// Optional feature: define CORR_ACCUM_SAT_EN to clamp dumps instead of
// truncating them.
module corr_accum_lane
  import corr_pkg::*;
#(
  parameter int IN_W    = CORR_IN_W,
  parameter int ACC_W   = CORR_ACC_W,
  parameter int OUT_W   = CORR_OUT_W,
  parameter int SHIFT_W = CORR_SHIFT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr_i,
  input  logic               epoch_i,
  input  logic [IN_W-1:0]    prod_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [OUT_W-1:0]   dump_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] prod_ext;
  logic [OUT_W-1:0] dump_q;
  logic [OUT_W-1:0] dump_d;
  logic [OUT_W-1:0] dump_slice;

  assign prod_ext = ACC_W'($signed(prod_i));

`ifdef CORR_ACCUM_SAT_EN
  assign dump_slice = OUT_W'(sat_slice(corr_ext_t'($signed(acc_q)), 32'(shift_i), 32'(OUT_W)));
`else
  assign dump_slice = OUT_W'(shift_slice(corr_ext_t'($signed(acc_q)), 32'(shift_i)));
`endif

  // Accumulator next state: clear wins, epoch restarts with this sample, else integrate.
  always_comb begin
    acc_d = acc_q + prod_ext;
    if (clr_i) begin
      acc_d = '0;
    end else if (epoch_i) begin
      acc_d = prod_ext;
    end
  end

  // Dump latch captures the pre-update accumulator on every epoch, clear or not.
  always_comb begin
    dump_d = dump_q;
    if (epoch_i) begin
      dump_d = dump_slice;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      dump_q <= '0;
    end else begin
      acc_q  <= acc_d;
      dump_q <= dump_d;
    end
  end

  assign dump_o = dump_q;

endmodule

// File: rtl/corr_accum_bank.sv
// Bank of 2*NTAPS correlator integrate-and-dump lanes with a shared dump
// status (valid / lost). Optional feature: CORR_ACCUM_SAT_EN selects saturating
// dumps in every lane.
//
// Dump handshake: dump_valid rises the cycle after epoch and stays high until a
// cycle with rd_ack=1 and epoch=0. An epoch in the same cycle as rd_ack counts
// as "old dump consumed, new dump delivered", so dump_valid stays 1 and no loss
// is flagged. An epoch while dump_valid=1 without rd_ack overwrites an unread
// dump and sets the sticky dump_lost, which only a channel clear resets.
module corr_accum_bank
  import corr_pkg::*;
#(
  parameter int NTAPS   = CORR_NTAPS,
  parameter int IN_W    = CORR_IN_W,
  parameter int ACC_W   = CORR_ACC_W,
  parameter int OUT_W   = CORR_OUT_W,
  parameter int SHIFT_W = CORR_SHIFT_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   doinit,
  input  logic                   intr_pulse,
  input  logic                   epoch,
  input  logic [NTAPS*IN_W-1:0]  prod_i,
  input  logic [NTAPS*IN_W-1:0]  prod_q,
  input  logic [SHIFT_W-1:0]     iq_shift,
  input  logic                   rd_ack,
  output logic [NTAPS*OUT_W-1:0] dump_i,
  output logic [NTAPS*OUT_W-1:0] dump_q,
  output logic                   dump_valid,
  output logic                   dump_lost
);

  // The largest shift must still leave OUT_W accumulator bits to dump.
  if (ACC_W < OUT_W + 2**SHIFT_W - 1) begin : g_width_chk
    $error("corr_accum_bank: ACC_W must be >= OUT_W + 2**SHIFT_W - 1");
  end
  if (ACC_W > CORR_EXT_W || ACC_W < IN_W) begin : g_range_chk
    $error("corr_accum_bank: ACC_W must lie between IN_W and 64");
  end

  logic clr;
  logic valid_q;
  logic valid_d;
  logic lost_q;
  logic lost_d;

  assign clr = doinit & intr_pulse;

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    corr_accum_lane #(
      .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)
    ) u_lane_i (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_i   (clr),
      .epoch_i (epoch),
      .prod_i  (prod_i[k*IN_W +: IN_W]),
      .shift_i (iq_shift),
      .dump_o  (dump_i[k*OUT_W +: OUT_W])
    );
    corr_accum_lane #(
      .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)
    ) u_lane_q (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_i   (clr),
      .epoch_i (epoch),
      .prod_i  (prod_q[k*IN_W +: IN_W]),
      .shift_i (iq_shift),
      .dump_o  (dump_q[k*OUT_W +: OUT_W])
    );
  end

  // Dump status next state: new dump sets valid, lone ack clears it; overrun beats clear.
  always_comb begin
    valid_d = valid_q;
    if (epoch) begin
      valid_d = 1'b1;
    end else if (rd_ack) begin
      valid_d = 1'b0;
    end
    lost_d = lost_q;
    if (clr) begin
      lost_d = 1'b0;
    end
    if (epoch && valid_q && !rd_ack) begin
      lost_d = 1'b1;
    end
  end

  // Status registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      lost_q  <= lost_d;
    end
  end

  assign dump_valid = valid_q;
  assign dump_lost  = lost_q;

endmodule

// File: tb/tb_corr_accum_bank.sv
// Directed testbench for corr_accum_bank: hand-computed dump values for
// integration, shift, overrun, clear and reset scenarios.
module tb_corr_accum_bank;

  localparam int NT = 5;
  localparam int IW = 5;
  localparam int AW = 19;
  localparam int OW = 16;
  localparam int SW = 2;
  localparam int TP = 2;  // prompt tap

  logic           clk = 1'b0;
  logic           reset_n;
  logic           doinit;
  logic           intr_pulse;
  logic           epoch;
  logic           rd_ack;
  logic [SW-1:0]  iq_shift;
  logic [NT*IW-1:0] prod_i;
  logic [NT*IW-1:0] prod_q;
  logic [NT*OW-1:0] dump_i;
  logic [NT*OW-1:0] dump_q;
  logic           dump_valid;
  logic           dump_lost;

  logic signed [IW-1:0] pi_v [NT];
  logic signed [IW-1:0] pq_v [NT];

  int checks   = 0;
  int failures = 0;

  int vi [NT] = '{1, 2, 3, -1, -2};
  int vq [NT] = '{-3, 4, -5, 6, 7};
  int wi [NT] = '{2, -4, -1, 5, 0};
  int wq [NT] = '{-7, 3, 0, -2, 9};
  int sat_exp;

  // Clock and DUT
  always #5 clk = ~clk;

  for (genvar g = 0; g < NT; g++) begin : g_pack
    assign prod_i[g*IW +: IW] = pi_v[g];
    assign prod_q[g*IW +: IW] = pq_v[g];
  end

  corr_accum_bank #(
    .NTAPS(NT), .IN_W(IW), .ACC_W(AW), .OUT_W(OW), .SHIFT_W(SW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .doinit     (doinit),
    .intr_pulse (intr_pulse),
    .epoch      (epoch),
    .prod_i     (prod_i),
    .prod_q     (prod_q),
    .iq_shift   (iq_shift),
    .rd_ack     (rd_ack),
    .dump_i     (dump_i),
    .dump_q     (dump_q),
    .dump_valid (dump_valid),
    .dump_lost  (dump_lost)
  );

  function automatic logic signed [OW-1:0] di(int k);
    return dump_i[k*OW +: OW];
  endfunction

  function automatic logic signed [OW-1:0] dq(int k);
    return dump_q[k*OW +: OW];
  endfunction

  // Scoreboard compare
  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver tasks: controls are applied for exactly one rising edge.
  task automatic step(input logic ep, input logic ack, input logic cl);
    epoch      = ep;
    rd_ack     = ack;
    doinit     = cl;
    intr_pulse = cl;
    @(posedge clk);
    #1;
    epoch      = 1'b0;
    rd_ack     = 1'b0;
    doinit     = 1'b0;
    intr_pulse = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < NT; k++) begin
      pi_v[k] = IW'(v);
      pq_v[k] = IW'(v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < NT; k++) begin
      chk($sformatf("%s_i%0d", tag, k), di(k), 0);
      chk($sformatf("%s_q%0d", tag, k), dq(k), 0);
    end
    chk($sformatf("%s_valid", tag), 32'(dump_valid), 0);
    chk($sformatf("%s_lost", tag), 32'(dump_lost), 0);
  endtask

  initial begin
    reset_n    = 1'b1;
    doinit     = 1'b0;
    intr_pulse = 1'b0;
    epoch      = 1'b0;
    rd_ack     = 1'b0;
    iq_shift   = '0;
    set_all(0);

    // Asynchronous reset state
    #2 reset_n = 1'b0;
    #1;
    chk_all_zero("reset");
    @(posedge clk);
    #2 reset_n = 1'b1;

    // 1000 cycles of per-tap products, then epoch at shift 0
    for (int k = 0; k < NT; k++) begin
      pi_v[k] = IW'(vi[k]);
      pq_v[k] = IW'(vq[k]);
    end
    run(1000);
    chk("t1_valid_pre", 32'(dump_valid), 0);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < NT; k++) begin
      chk($sformatf("t1_i%0d", k), di(k), 1000 * vi[k]);
      chk($sformatf("t1_q%0d", k), dq(k), 1000 * vq[k]);
    end
    chk("t1_valid", 32'(dump_valid), 1);
    chk("t1_lost", 32'(dump_lost), 0);

    // Epoch sample starts the next interval; ack clears valid but not data
    for (int k = 0; k < NT; k++) begin
      pi_v[k] = IW'(wi[k]);
      pq_v[k] = IW'(wq[k]);
    end
    run(998);
    step(1'b0, 1'b1, 1'b0);
    chk("t2_valid_acked", 32'(dump_valid), 0);
    chk("t2_hold_p", di(TP), 3000);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < NT; k++) begin
      chk($sformatf("t2_i%0d", k), di(k), vi[k] + 999 * wi[k]);
      chk($sformatf("t2_q%0d", k), dq(k), vq[k] + 999 * wq[k]);
    end
    chk("t2_valid", 32'(dump_valid), 1);
    chk("t2_lost", 32'(dump_lost), 0);

    // -16 for 4096 cycles: shift 2 then shift 3
    set_all(-16);
    iq_shift = 2'd2;
    step(1'b0, 1'b1, 1'b1);
    chk("t3_valid_clr", 32'(dump_valid), 0);
    run(4096);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < NT; k++) begin
      chk($sformatf("t3_s2_i%0d", k), di(k), -16384);
    end
    chk("t3_s2_q_p", dq(TP), -16384);
    chk("t3_s2_lost", 32'(dump_lost), 0);
    run(4095);
    iq_shift = 2'd3;
    step(1'b1, 1'b1, 1'b0);
    chk("t3_s3_i_p", di(TP), -8192);
    chk("t3_s3_q_ee", dq(0), -8192);
    chk("t3_s3_valid", 32'(dump_valid), 1);
    chk("t3_s3_lost", 32'(dump_lost), 0);

    // Overrun: two epochs without ack, then epoch together with ack
    set_all(2);
    iq_shift = 2'd0;
    run(9);
    step(1'b1, 1'b0, 1'b0);
    chk("t4_first_i", di(TP), 2);
    chk("t4_first_lost", 32'(dump_lost), 1);
    run(4);
    step(1'b1, 1'b0, 1'b0);
    chk("t4_second_i", di(TP), 10);
    chk("t4_second_q", dq(4), 10);
    chk("t4_second_lost", 32'(dump_lost), 1);
    run(2);
    step(1'b1, 1'b1, 1'b0);
    chk("t4_ackep_i", di(TP), 6);
    chk("t4_ackep_valid", 32'(dump_valid), 1);
    chk("t4_ackep_lost", 32'(dump_lost), 1);

    // Clear with epoch: dump keeps prior sum, accumulator restarts at 0
    run(3);
    step(1'b1, 1'b1, 1'b1);
    chk("t5_clrep_i", di(TP), 8);
    chk("t5_clrep_lost", 32'(dump_lost), 0);
    chk("t5_clrep_valid", 32'(dump_valid), 1);
    run(5);
    step(1'b1, 1'b1, 1'b0);
    chk("t5_after_clr_i", di(TP), 10);
    chk("t5_after_clr_lost", 32'(dump_lost), 0);
    step(1'b1, 1'b0, 1'b1);
    chk("t5_setwins_i", di(TP), 2);
    chk("t5_setwins_lost", 32'(dump_lost), 1);
    step(1'b0, 1'b0, 1'b1);
    chk("t5_clr_lost", 32'(dump_lost), 0);
    chk("t5_clr_valid", 32'(dump_valid), 1);

    // +15 for 4000 cycles: sum 60000 overflows the 16-bit dump
`ifdef CORR_ACCUM_SAT_EN
    sat_exp = 32767;
`else
    sat_exp = -5536;
`endif
    set_all(15);
    step(1'b0, 1'b1, 1'b1);
    run(4000);
    step(1'b1, 1'b0, 1'b0);
    chk("t6_big_i_p", di(TP), sat_exp);
    chk("t6_big_q_p", dq(TP), sat_exp);
    chk("t6_big_i_ll", di(4), sat_exp);

    // Reset mid-interval discards the partial sum
    set_all(1);
    run(50);
    #2 reset_n = 1'b0;
    #1;
    chk_all_zero("t7_rst");
    @(posedge clk);
    #2 reset_n = 1'b1;
    run(20);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < NT; k++) begin
      chk($sformatf("t7_i%0d", k), di(k), 20);
      chk($sformatf("t7_q%0d", k), dq(k), 20);
    end
    chk("t7_valid", 32'(dump_valid), 1);
    chk("t7_lost", 32'(dump_lost), 0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
